// File: rtl/ext_mem_bridge_pkg.sv
// Shared types and constants for the external memory bridge.
package ext_mem_bridge_pkg;

  // Bridge sequencer states
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } bridge_state_e;

  // Value returned on rsp_rdata when the slave times out
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADC0DE5;

  // One queued request: {wr, byte_en[3:0], wdata[31:0], addr[31:0]}
  typedef struct packed {
    logic        wr;
    logic [3:0]  byte_en;
    logic [31:0] wdata;
    logic [31:0] addr;
  } req_entry_t;

  localparam int unsigned REQ_W = $bits(req_entry_t);

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

endpackage

// File: rtl/ext_req_fifo.sv
// Small request FIFO with registered full/empty flags and explicit pointer wrap.
module ext_req_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  assign do_push    = push_i & ~full_q;
  assign do_pop     = pop_i & ~empty_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;

  // Next-state for storage, pointers, occupancy and flags
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_d[i] = mem_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
    end

    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    full_d  = (count_d == CntW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // FIFO state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

endmodule

// File: rtl/ext_mem_bridge.sv
// Queues core memory requests and sequences them one at a time onto a slave bus,
// returning one in-order response per request; a hung slave becomes an error response.
module ext_mem_bridge
  import ext_mem_bridge_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [31:0] ERR_RDATA  = ERR_RDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_wr_en,
  input  logic        req_rd_en,
  input  logic [3:0]  req_byte_en,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_wr_en,
  output logic        bus_rd_en,
  output logic [3:0]  bus_byte_en,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic        busy,
  output logic [7:0]  timeout_cnt
);

  // Last wait-counter value before the abort cycle
  localparam logic [15:0] WaitLast = 16'(TIMEOUT - 1);

  bridge_state_e state_q, state_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic [3:0]    bus_byte_en_q, bus_byte_en_d;
  logic          bus_wr_q, bus_wr_d;
  logic          bus_rd_q, bus_rd_d;
  logic [15:0]   wait_cnt_q, wait_cnt_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic [7:0]    timeout_cnt_q, timeout_cnt_d;

  req_entry_t    push_entry;
  req_entry_t    head_entry;
  logic          fifo_push, fifo_pop;
  logic          fifo_full, fifo_empty;

  // Both enables high is treated as a write
  always_comb begin
    push_entry.wr      = req_wr_en;
    push_entry.byte_en = req_byte_en;
    push_entry.wdata   = req_wdata;
    push_entry.addr    = req_addr;
  end

  assign req_ready = ~fifo_full;
  assign fifo_push = (req_wr_en | req_rd_en) & ~fifo_full;

  ext_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (fifo_push),
    .push_data_i (push_entry),
    .pop_i       (fifo_pop),
    .pop_data_o  (head_entry),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Sequencer next-state: issue head of queue, wait for slave or timeout, respond
  always_comb begin
    state_d       = state_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    bus_byte_en_d = bus_byte_en_q;
    bus_wr_d      = bus_wr_q;
    bus_rd_d      = bus_rd_q;
    wait_cnt_d    = wait_cnt_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    timeout_cnt_d = timeout_cnt_q;
    fifo_pop      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
        end
      end
      StAccess: begin
        wait_cnt_d = wait_cnt_q + 16'd1;
        if (bus_ready) begin
          bus_wr_d    = 1'b0;
          bus_rd_d    = 1'b0;
          rsp_rdata_d = bus_rd_q ? bus_rdata : 32'h0;
          rsp_err_d   = 1'b0;
          state_d     = StResp;
        end else if (wait_cnt_q == WaitLast) begin
          bus_wr_d    = 1'b0;
          bus_rd_d    = 1'b0;
          rsp_rdata_d = ERR_RDATA;
          rsp_err_d   = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (rsp_err_q) begin
          timeout_cnt_d = sat_inc8(timeout_cnt_q);
        end
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Popping always launches a fresh access from the head entry
    if (fifo_pop) begin
      bus_addr_d    = head_entry.addr;
      bus_wdata_d   = head_entry.wdata;
      bus_byte_en_d = head_entry.byte_en;
      bus_wr_d      = head_entry.wr;
      bus_rd_d      = ~head_entry.wr;
      wait_cnt_d    = '0;
      state_d       = StAccess;
    end
  end

  // Sequencer, bus and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      bus_byte_en_q <= '0;
      bus_wr_q      <= 1'b0;
      bus_rd_q      <= 1'b0;
      wait_cnt_q    <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      timeout_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      bus_byte_en_q <= bus_byte_en_d;
      bus_wr_q      <= bus_wr_d;
      bus_rd_q      <= bus_rd_d;
      wait_cnt_q    <= wait_cnt_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  // Response fields are forced to zero outside the response pulse
  always_comb begin
    rsp_valid = (state_q == StResp);
    rsp_rdata = rsp_valid ? rsp_rdata_q : 32'h0;
    rsp_err   = rsp_valid & rsp_err_q;
  end

  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign bus_byte_en = bus_byte_en_q;
  assign bus_wr_en   = bus_wr_q;
  assign bus_rd_en   = bus_rd_q;
  assign busy        = ~fifo_empty | (state_q != StIdle);
  assign timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_ext_mem_bridge.sv
// Directed bench for ext_mem_bridge with a simple programmable slave.
module tb_ext_mem_bridge;

  localparam int unsigned TO     = 8;
  localparam logic [31:0] RD_KEY = 32'h5A5A_0000;

  logic        clk;
  logic        rst;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_wr_en;
  logic        req_rd_en;
  logic [3:0]  req_byte_en;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_wr_en;
  logic        bus_rd_en;
  logic [3:0]  bus_byte_en;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        busy;
  logic [7:0]  timeout_cnt;

  ext_mem_bridge #(
    .FIFO_DEPTH (2),
    .TIMEOUT    (TO),
    .ERR_RDATA  (32'hBADC0DE5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_wr_en   (req_wr_en),
    .req_rd_en   (req_rd_en),
    .req_byte_en (req_byte_en),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_wr_en   (bus_wr_en),
    .bus_rd_en   (bus_rd_en),
    .bus_byte_en (bus_byte_en),
    .bus_rdata   (bus_rdata),
    .bus_ready   (bus_ready),
    .busy        (busy),
    .timeout_cnt (timeout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave: ready after slave_wait stall cycles unless hung; data fixed or address-derived
  int          acc_cnt = 0;
  int          slave_wait = 0;
  bit          slave_hang = 0;
  bit          slave_fixed_en = 0;
  logic [31:0] slave_fixed = '0;

  always @(negedge clk) begin
    if (bus_rd_en || bus_wr_en) begin
      acc_cnt   = acc_cnt + 1;
      bus_ready = !slave_hang && (acc_cnt == slave_wait + 1);
      bus_rdata = slave_fixed_en ? slave_fixed : (bus_addr ^ RD_KEY);
    end else begin
      acc_cnt   = 0;
      bus_ready = 1'b0;
      bus_rdata = '0;
    end
  end

  // Response collector: {err, rdata}
  logic [32:0] rsp_q[$];
  always @(negedge clk) begin
    if (rsp_valid) rsp_q.push_back({rsp_err, rsp_rdata});
  end

  // Caller sits at a negedge; returns at the negedge after the accepting edge
  task automatic push_req(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                          input logic rd, input logic [3:0] be, output int waited);
    int g;
    req_addr = a; req_wdata = wd; req_wr_en = wr; req_rd_en = rd; req_byte_en = be;
    g = 0;
    while (!req_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check_eq("push_ready", 32'(req_ready), 32'd1);
    waited = g;
    @(posedge clk);
    @(negedge clk);
    req_wr_en = 1'b0;
    req_rd_en = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    @(negedge clk);
    while (busy && g < 100) begin
      @(negedge clk);
      g++;
    end
    check_eq("idle", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog");
  end

  int w;
  int hi;
  logic [31:0] t3_addr [4];

  initial begin
    rst = 1'b1;
    req_addr = '0; req_wdata = '0; req_wr_en = 1'b0; req_rd_en = 1'b0; req_byte_en = '0;
    bus_rdata = '0; bus_ready = 1'b0;
    #3;
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_bus_strobes", 32'({bus_wr_en, bus_rd_en}), 32'd0);
    check_eq("rst_bus_addr", bus_addr, 32'h0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: zero-wait read, response 3 cycles after push
    slave_fixed_en = 1; slave_fixed = 32'h1234_5678; slave_wait = 0;
    push_req(32'h0000_1000, 32'h0, 1'b0, 1'b1, 4'hF, w);
    check_eq("t1_rsp_early", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check_eq("t1_bus_rd", 32'(bus_rd_en), 32'd1);
    check_eq("t1_bus_wr", 32'(bus_wr_en), 32'd0);
    check_eq("t1_bus_addr", bus_addr, 32'h0000_1000);
    check_eq("t1_rsp_early2", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check_eq("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("t1_rdata", rsp_rdata, 32'h1234_5678);
    check_eq("t1_err", 32'(rsp_err), 32'd0);
    wait_idle();

    // 2: write with 4 slave wait cycles, bus held for 5 cycles
    slave_wait = 4;
    push_req(32'h0000_2000, 32'hCAFE_F00D, 1'b1, 1'b0, 4'b0011, w);
    @(negedge clk);
    hi = 0;
    while (bus_wr_en && hi < 20) begin
      check_eq("t2_addr", bus_addr, 32'h0000_2000);
      check_eq("t2_wdata", bus_wdata, 32'hCAFE_F00D);
      check_eq("t2_be", 32'(bus_byte_en), 32'h3);
      hi++;
      @(negedge clk);
    end
    check_eq("t2_cycles", 32'(hi), 32'd5);
    check_eq("t2_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("t2_rdata", rsp_rdata, 32'h0);
    check_eq("t2_err", 32'(rsp_err), 32'd0);
    wait_idle();

    // 3: stalled slave, FIFO fills, later request waits for a pop, in-order responses
    slave_fixed_en = 0; slave_wait = 3;
    t3_addr[0] = 32'h0000_3000; t3_addr[1] = 32'h0000_3100;
    t3_addr[2] = 32'h0000_3200; t3_addr[3] = 32'h0000_3300;
    rsp_q.delete();
    push_req(t3_addr[0], 32'h0, 1'b0, 1'b1, 4'hF, w);
    push_req(t3_addr[1], 32'h0, 1'b0, 1'b1, 4'hF, w);
    push_req(t3_addr[2], 32'h0, 1'b0, 1'b1, 4'hF, w);
    check_eq("t3_full_ready", 32'(req_ready), 32'd0);
    push_req(t3_addr[3], 32'h0, 1'b0, 1'b1, 4'hF, w);
    check_eq("t3_blocked_cycles", 32'(w), 32'd4);
    wait_idle();
    check_eq("t3_rsp_count", 32'(rsp_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < rsp_q.size()) begin
        check_eq("t3_order_rdata", rsp_q[i][31:0], t3_addr[i] ^ RD_KEY);
        check_eq("t3_order_err", 32'(rsp_q[i][32]), 32'd0);
      end
    end

    // 6: both enables high is a write
    slave_wait = 0;
    rsp_q.delete();
    push_req(32'h0000_6000, 32'h1111_2222, 1'b1, 1'b1, 4'hF, w);
    @(negedge clk);
    check_eq("t6_bus_wr", 32'(bus_wr_en), 32'd1);
    check_eq("t6_bus_rd", 32'(bus_rd_en), 32'd0);
    check_eq("t6_wdata", bus_wdata, 32'h1111_2222);
    wait_idle();
    check_eq("t6_rsp_count", 32'(rsp_q.size()), 32'd1);
    if (rsp_q.size() > 0) check_eq("t6_rdata", rsp_q[0][31:0], 32'h0);

    // 4: hung slave, timeout after TO access cycles, saturating counter
    slave_hang = 1;
    rsp_q.delete();
    push_req(32'h0000_4000, 32'h0, 1'b0, 1'b1, 4'hF, w);
    @(negedge clk);
    hi = 0;
    while (bus_rd_en && hi < 50) begin
      hi++;
      @(negedge clk);
    end
    check_eq("t4_cycles", 32'(hi), 32'(TO));
    check_eq("t4_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("t4_err", 32'(rsp_err), 32'd1);
    check_eq("t4_rdata", rsp_rdata, 32'hBADC_0DE5);
    wait_idle();
    check_eq("t4_cnt1", 32'(timeout_cnt), 32'd1);
    for (int i = 0; i < 254; i++) begin
      push_req(32'h0000_4004, 32'h0, 1'b0, 1'b1, 4'hF, w);
      wait_idle();
    end
    check_eq("t4_cnt255", 32'(timeout_cnt), 32'd255);
    for (int i = 0; i < 5; i++) begin
      push_req(32'h0000_4008, 32'h0, 1'b0, 1'b1, 4'hF, w);
      wait_idle();
    end
    check_eq("t4_cnt_sat", 32'(timeout_cnt), 32'd255);
    check_eq("t4_rsp_count", 32'(rsp_q.size()), 32'd260);

    // 5: async reset mid-access drops it without a response
    slave_hang = 0; slave_wait = 5;
    rsp_q.delete();
    push_req(32'h0000_5000, 32'h0, 1'b0, 1'b1, 4'hF, w);
    @(negedge clk);
    @(negedge clk);
    check_eq("t5_pre_rd", 32'(bus_rd_en), 32'd1);
    check_eq("t5_pre_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t5_rst_strobes", 32'({bus_wr_en, bus_rd_en}), 32'd0);
    check_eq("t5_rst_busy", 32'(busy), 32'd0);
    check_eq("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("t5_rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check_eq("t5_no_rsp", 32'(rsp_q.size()), 32'd0);
    @(negedge clk);
    slave_fixed_en = 1; slave_fixed = 32'hA5A5_0001; slave_wait = 0;
    push_req(32'h0000_1000, 32'h0, 1'b0, 1'b1, 4'hF, w);
    @(negedge clk);
    check_eq("t5_again_rd", 32'(bus_rd_en), 32'd1);
    check_eq("t5_again_early", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check_eq("t5_again_valid", 32'(rsp_valid), 32'd1);
    check_eq("t5_again_rdata", rsp_rdata, 32'hA5A5_0001);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
